// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU (port 0) and
// DMA/debug (port 1), with round-robin ties, port-1 bursts and a CPU starvation guard.
module dm_arbiter #(
   parameter int DEPTH    = 3072,
   parameter int AW       = 12,
   parameter int MAX_WAIT = 4,
   parameter int LEN_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             we0,
   input  logic [31:0]      addr0,
   input  logic [31:0]      wd0,
   input  logic [3:0]       be0,
   output logic             gnt0,
   output logic [31:0]      rd0,
   input  logic             req1,
   input  logic             we1,
   input  logic [31:0]      addr1,
   input  logic [31:0]      wd1,
   input  logic [3:0]       be1,
   input  logic [LEN_W-1:0] len1,
   output logic             gnt1,
   output logic [31:0]      rd1,
   output logic             err,
   output logic [AW-1:0]    mem_addr,
   output logic [31:0]      mem_wd,
   output logic [3:0]       mem_be,
   output logic             mem_we,
   output logic             mem_re,
   input  logic [31:0]      mem_rd
);

   localparam int          WW    = $clog2(MAX_WAIT + 1);
   localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

   typedef enum logic {IDLE, BURST} state_t;

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic [LEN_W-1:0] beats_q, beats_d;
   logic [WW-1:0]    wait0_q, wait0_d;

   logic             preempt;
   logic             any_gnt;
   logic             we_sel;
   logic [31:0]      addr_sel;
   logic [LEN_W-1:0] eff_len;

   always_comb begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      preempt = (state_q == BURST) && req0 && (wait0_q == WW'(MAX_WAIT));
      if (!reset) begin
         if (state_q == BURST) begin
            // with req1 low the burst is aborting, so the CPU may take the slot
            if (preempt)   gnt0 = 1'b1;
            else if (req1) gnt1 = 1'b1;
            else           gnt0 = req0;
         end else if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   always_comb begin
      any_gnt  = gnt0 | gnt1;
      addr_sel = gnt1 ? addr1 : addr0;
      we_sel   = gnt1 ? we1   : we0;
      mem_wd   = gnt1 ? wd1   : wd0;
      mem_be   = gnt1 ? be1   : be0;
      mem_addr = addr_sel[AW+1:2];
      err      = any_gnt && (addr_sel >= LIMIT);
      mem_we   = any_gnt &  we_sel & ~err;
      mem_re   = any_gnt & ~we_sel & ~err;
      rd0      = (gnt0 & ~we0 & ~err) ? mem_rd : '0;
      rd1      = (gnt1 & ~we1 & ~err) ? mem_rd : '0;
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      beats_d = beats_q;
      wait0_d = wait0_q;
      eff_len = (len1 == '0) ? LEN_W'(1) : len1;

      if (gnt0 || !req0)              wait0_d = '0;
      else if (wait0_q != WW'(MAX_WAIT)) wait0_d = wait0_q + WW'(1);

      if (gnt0)      last_d = 1'b0;
      else if (gnt1) last_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (gnt1 && (eff_len > LEN_W'(1))) begin
               state_d = BURST;
               beats_d = eff_len - LEN_W'(1);
            end
         end
         BURST: begin
            if (!req1) begin
               state_d = IDLE;
               beats_d = '0;
            end else if (gnt1) begin
               beats_d = beats_q - LEN_W'(1);
               if (beats_q == LEN_W'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         beats_q <= '0;
         wait0_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         beats_q <= beats_d;
         wait0_q <= wait0_d;
      end
   end

endmodule
